// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-port integer register file with optional
//                same-cycle write-to-read bypass, optional hardwired-zero r0
//                and a per-register busy scoreboard for in-flight writebacks.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRP     = 2,
    parameter int NWP     = 1,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NWP-1:0]        i_wen,
    input  logic [NWP*AW-1:0]     i_waddr,
    input  logic [NWP*XLEN-1:0]   i_wdata,
    input  logic [NRP*AW-1:0]     i_raddr,
    output logic [NRP*XLEN-1:0]   o_rdata,
    output logic [NRP-1:0]        o_rbusy,
    input  logic                  i_rsv_en,
    input  logic [AW-1:0]         i_rsv_addr,
    output logic [NREG-1:0]       o_busy
);

    // Current contents of every register and its busy flag, gathered from
    // the per-register storage below so the read ports can index them.
    logic [NREG-1:0][XLEN-1:0] w_regs;
    logic [NREG-1:0]           w_busy;

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if ((ZERO_R0 != 0) && (i == 0)) begin : g_hardwired
            // r0 has no storage at all: writes and reservations simply vanish.
            assign w_regs[i] = '0;
            assign w_busy[i] = 1'b0;
        end else begin : g_storage
            logic            w_we;
            logic [XLEN-1:0] w_wd;
            logic            w_rsv_hit;
            logic [XLEN-1:0] r_q;
            logic            r_busy;

            assign w_rsv_hit = i_rsv_en && (i_rsv_addr == AW'(i));

            // Select the write aimed at this register; higher ports override lower ones.
            always_comb begin
                w_we = 1'b0;
                w_wd = '0;
                for (int k = 0; k < NWP; k++) begin
                    if (i_wen[k] && (i_waddr[k*AW +: AW] == AW'(i))) begin
                        w_we = 1'b1;
                        w_wd = i_wdata[k*XLEN +: XLEN];
                    end
                end
            end

            // Register storage and busy flag; a same-edge reserve beats the
            // clearing writeback because a younger instruction now owns it.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_q    <= '0;
                    r_busy <= 1'b0;
                end else begin
                    if (w_we) begin
                        r_q <= w_wd;
                    end
                    if (w_rsv_hit) begin
                        r_busy <= 1'b1;
                    end else if (w_we) begin
                        r_busy <= 1'b0;
                    end
                end
            end

            assign w_regs[i] = r_q;
            assign w_busy[i] = r_busy;
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_val;

        assign w_ra = i_raddr[k*AW +: AW];

        // Read mux with optional bypass of the winning same-cycle write;
        // r0 and reset force zero regardless of what is being written.
        always_comb begin
            w_val = w_regs[w_ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWP; j++) begin
                    if (i_wen[j] && (i_waddr[j*AW +: AW] == w_ra)) begin
                        w_val = i_wdata[j*XLEN +: XLEN];
                    end
                end
            end
            if (((ZERO_R0 != 0) && (w_ra == '0)) || i_rst) begin
                w_val = '0;
            end
        end

        assign o_rdata[k*XLEN +: XLEN] = w_val;
        // Busy reflects registered state only; reservations are not bypassed.
        assign o_rbusy[k]              = w_busy[w_ra] & ~i_rst;
    end

    assign o_busy = w_busy;

endmodule
`default_nettype wire
